// File: rtl/nasti_burst_sequencer.sv
`default_nettype none
// nasti_burst_sequencer: pops AR/AW bursts, round-robin arbitrates them, expands them into backend beat
// commands, returns in-order read data and write responses. Optional feature macro: NASTI_SEQ_LAST_CHECK_EN.
// Packing (MSB..LSB): ax={id,addr,len[7:0],size[2:0],burst[1:0],user}  w={data,strb,last,user}
//                     b={id,resp[1:0],user}  r={id,data,last,resp[1:0],user}
// Revision: 1.0
module nasti_burst_sequencer #(
  parameter int C_NASTI_ID_WIDTH   = 4,
  parameter int C_NASTI_ADDR_WIDTH = 32,
  parameter int C_NASTI_DATA_WIDTH = 64,
  parameter int C_NASTI_USER_WIDTH = 1,
  parameter int C_MAX_PENDING      = 5,
  localparam int IW   = C_NASTI_ID_WIDTH,
  localparam int ADW  = C_NASTI_ADDR_WIDTH,
  localparam int DW   = C_NASTI_DATA_WIDTH,
  localparam int SW   = C_NASTI_DATA_WIDTH / 8,
  localparam int UW   = C_NASTI_USER_WIDTH,
  localparam int AX_W = IW + ADW + 8 + 3 + 2 + UW,
  localparam int W_W  = DW + SW + 1 + UW,
  localparam int B_W  = IW + 2 + UW,
  localparam int R_W  = IW + DW + 1 + 2 + UW
) (
  input  logic            core_clk,
  input  logic            core_arstn,
  input  logic [AX_W-1:0] ar_rdata,
  input  logic            ar_rempty,
  output logic            ar_rden,
  input  logic [AX_W-1:0] aw_rdata,
  input  logic            aw_rempty,
  output logic            aw_rden,
  input  logic [W_W-1:0]  w_rdata,
  input  logic            w_rempty,
  output logic            w_rden,
  output logic [B_W-1:0]  b_wdata,
  input  logic            b_wfull,
  output logic            b_wren,
  output logic [R_W-1:0]  r_wdata,
  input  logic            r_wfull,
  output logic            r_wren,
  output logic            cmd_valid,
  input  logic            cmd_ready,
  output logic            cmd_write,
  output logic [ADW-1:0]  cmd_addr,
  output logic [DW-1:0]   cmd_wdata,
  output logic [SW-1:0]   cmd_wstrb,
  input  logic            rsp_valid,
  output logic            rsp_ready,
  input  logic [DW-1:0]   rsp_data
);

  typedef struct packed {
    logic [IW-1:0]  id;
    logic [ADW-1:0] addr;
    logic [7:0]     len;
    logic [2:0]     size;
    logic [1:0]     burst;
    logic [UW-1:0]  user;
  } ax_t;

  typedef struct packed {
    logic [DW-1:0] data;
    logic [SW-1:0] strb;
    logic          last;
    logic [UW-1:0] user;
  } w_t;

  typedef struct packed {
    logic [IW-1:0] id;
    logic [1:0]    resp;
    logic [UW-1:0] user;
  } b_t;

  typedef struct packed {
    logic [IW-1:0] id;
    logic [DW-1:0] data;
    logic          last;
    logic [1:0]    resp;
    logic [UW-1:0] user;
  } r_t;

  typedef struct packed {
    logic [IW-1:0] id;
    logic [UW-1:0] user;
    logic          last;
  } tag_t;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_RD    = 2'd1;
  localparam logic [1:0] S_WR    = 2'd2;
  localparam logic [1:0] S_WRESP = 2'd3;

  localparam int PW = (C_MAX_PENDING > 1) ? $clog2(C_MAX_PENDING) : 1;
  localparam int CW = $clog2(C_MAX_PENDING + 1);

  ax_t ar_head, aw_head, gnt_head;
  w_t  w_head;
  b_t  b_out;
  r_t  r_out;

  logic [1:0]     state_q, state_d;
  logic           last_wr_q;
  logic           ar_pop_q, aw_pop_q;
  logic [IW-1:0]  id_q;
  logic [ADW-1:0] addr_q, addr_d;
  logic [7:0]     len_q, beat_q;
  logic [2:0]     size_q;
  logic [1:0]     burst_q;
  logic [UW-1:0]  user_q;
  logic [1:0]     b_resp;

  logic gnt_rd, gnt_wr, cmd_hs, last_beat;
  logic [ADW-1:0] step, wrap_mask;
  logic           wrap_ok;

  tag_t          tag_mem_q [C_MAX_PENDING];
  logic [PW-1:0] tag_wp_q, tag_rp_q;
  logic [CW-1:0] tag_cnt_q;
  logic          tag_full, tag_empty, tag_push, tag_pop;
  tag_t          tag_in, tag_head;

  assign ar_head = ar_rdata;
  assign aw_head = aw_rdata;
  assign w_head  = w_rdata;

  // last_wr_q remembers the previous winner so a contested IDLE cycle alternates
  assign gnt_rd   = (state_q == S_IDLE) && !ar_rempty && (aw_rempty || last_wr_q);
  assign gnt_wr   = (state_q == S_IDLE) && !aw_rempty && !gnt_rd;
  assign gnt_head = gnt_rd ? ar_head : aw_head;

  assign cmd_hs    = cmd_valid && cmd_ready;
  assign last_beat = (beat_q == len_q);

  always_ff @(posedge core_clk or negedge core_arstn) begin
    if (!core_arstn) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (gnt_rd)      state_d = S_RD;
        else if (gnt_wr) state_d = S_WR;
      end
      S_RD:    if (cmd_hs && last_beat) state_d = S_IDLE;
      S_WR:    if (cmd_hs && last_beat) state_d = S_WRESP;
      S_WRESP: if (!b_wfull)            state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    cmd_valid = 1'b0;
    cmd_write = 1'b0;
    cmd_wdata = '0;
    cmd_wstrb = '0;
    w_rden    = 1'b0;
    b_wren    = 1'b0;
    case (state_q)
      S_RD: cmd_valid = !tag_full;
      S_WR: begin
        cmd_valid = !w_rempty;
        cmd_write = 1'b1;
        cmd_wdata = w_head.data;
        cmd_wstrb = w_head.strb;
        w_rden    = !w_rempty && cmd_ready;
      end
      S_WRESP: b_wren = !b_wfull;
      default: ;
    endcase
  end

  // FIFO pops are registered: the head was latched at grant and stays valid until this pop
  assign ar_rden  = ar_pop_q;
  assign aw_rden  = aw_pop_q;
  assign cmd_addr = addr_q;

  always_comb begin
    step      = ADW'(1) << size_q;
    wrap_mask = ((ADW'(len_q) + ADW'(1)) << size_q) - ADW'(1);
    wrap_ok   = (len_q == 8'd1) || (len_q == 8'd3) || (len_q == 8'd7) || (len_q == 8'd15);
    addr_d    = addr_q + step;
    if (burst_q == 2'b00) begin
      addr_d = addr_q;
    end else if ((burst_q == 2'b10) && wrap_ok) begin
      addr_d = (addr_q & ~wrap_mask) | ((addr_q + step) & wrap_mask);
    end
  end

  always_ff @(posedge core_clk or negedge core_arstn) begin
    if (!core_arstn) begin
      last_wr_q <= 1'b1;
      ar_pop_q  <= 1'b0;
      aw_pop_q  <= 1'b0;
      id_q      <= '0;
      addr_q    <= '0;
      len_q     <= '0;
      size_q    <= '0;
      burst_q   <= '0;
      user_q    <= '0;
      beat_q    <= '0;
    end else begin
      ar_pop_q <= gnt_rd;
      aw_pop_q <= gnt_wr;
      if (gnt_rd || gnt_wr) begin
        last_wr_q <= gnt_wr;
        id_q      <= gnt_head.id;
        addr_q    <= gnt_head.addr;
        len_q     <= gnt_head.len;
        size_q    <= gnt_head.size;
        burst_q   <= gnt_head.burst;
        user_q    <= gnt_head.user;
        beat_q    <= '0;
      end else if (cmd_hs) begin
        addr_q <= addr_d;
        beat_q <= beat_q + 8'd1;
      end
    end
  end

`ifdef NASTI_SEQ_LAST_CHECK_EN
  logic err_q;
  logic unused_w;

  always_ff @(posedge core_clk or negedge core_arstn) begin
    if (!core_arstn) begin
      err_q <= 1'b0;
    end else if (gnt_wr) begin
      err_q <= 1'b0;
    end else if ((state_q == S_WR) && cmd_hs && (w_head.last != last_beat)) begin
      err_q <= 1'b1;
    end
  end

  assign b_resp   = err_q ? 2'b10 : 2'b00;
  assign unused_w = ^w_head.user;
`else
  logic unused_w;

  assign b_resp   = 2'b00;
  assign unused_w = ^{w_head.last, w_head.user};
`endif

  assign b_out.id   = id_q;
  assign b_out.resp = b_resp;
  assign b_out.user = user_q;
  assign b_wdata    = b_out;

  // Read tag queue: one entry per issued read beat, popped as data returns in order
  assign tag_full  = (tag_cnt_q == CW'(C_MAX_PENDING));
  assign tag_empty = (tag_cnt_q == '0);
  assign tag_push  = (state_q == S_RD) && cmd_hs;
  assign tag_pop   = r_wren;
  assign tag_in    = '{id: id_q, user: user_q, last: last_beat};
  assign tag_head  = tag_mem_q[tag_rp_q];

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(C_MAX_PENDING - 1)) ? '0 : p + PW'(1);
  endfunction

  always_ff @(posedge core_clk or negedge core_arstn) begin
    if (!core_arstn) begin
      tag_wp_q  <= '0;
      tag_rp_q  <= '0;
      tag_cnt_q <= '0;
      for (int i = 0; i < C_MAX_PENDING; i++) begin
        tag_mem_q[i] <= '0;
      end
    end else begin
      if (tag_push) begin
        tag_mem_q[tag_wp_q] <= tag_in;
        tag_wp_q            <= ptr_inc(tag_wp_q);
      end
      if (tag_pop) begin
        tag_rp_q <= ptr_inc(tag_rp_q);
      end
      if (tag_push && !tag_pop) begin
        tag_cnt_q <= tag_cnt_q + CW'(1);
      end else if (!tag_push && tag_pop) begin
        tag_cnt_q <= tag_cnt_q - CW'(1);
      end
    end
  end

  assign rsp_ready  = !r_wfull && !tag_empty;
  assign r_wren     = rsp_valid && rsp_ready;
  assign r_out.id   = tag_head.id;
  assign r_out.data = rsp_data;
  assign r_out.last = tag_head.last;
  assign r_out.resp = 2'b00;
  assign r_out.user = tag_head.user;
  assign r_wdata    = r_wren ? r_out : '0;

endmodule
`default_nettype wire

// File: tb/tb_nasti_burst_sequencer.sv
`default_nettype none
// Testbench for nasti_burst_sequencer: FWFT FIFO and backend models feeding command/R/B scoreboards.
module tb_nasti_burst_sequencer;
  localparam int IW = 4, ADW = 16, DW = 32, SW = 4, UW = 2, MAXP = 5;
  localparam int AX_W = IW + ADW + 8 + 3 + 2 + UW;
  localparam int W_W  = DW + SW + 1 + UW;
  localparam int B_W  = IW + 2 + UW;
  localparam int R_W  = IW + DW + 1 + 2 + UW;
  localparam logic [DW-1:0] RD_BASE = 32'hA5C3_0000;
`ifdef NASTI_SEQ_LAST_CHECK_EN
  localparam logic [1:0] LAST_ERR_RESP = 2'b10;
`else
  localparam logic [1:0] LAST_ERR_RESP = 2'b00;
`endif

  typedef struct packed {
    logic [IW-1:0] id; logic [ADW-1:0] addr; logic [7:0] len;
    logic [2:0] size; logic [1:0] burst; logic [UW-1:0] user;
  } ax_t;
  typedef struct packed { logic [DW-1:0] data; logic [SW-1:0] strb; logic last; logic [UW-1:0] user; } w_t;
  typedef struct packed { logic [IW-1:0] id; logic [1:0] resp; logic [UW-1:0] user; } b_t;
  typedef struct packed {
    logic [IW-1:0] id; logic [DW-1:0] data; logic last; logic [1:0] resp; logic [UW-1:0] user;
  } r_t;
  typedef struct packed { logic write; logic [ADW-1:0] addr; logic [DW-1:0] wdata; logic [SW-1:0] wstrb; } cmd_t;
  typedef struct {
    logic wr; logic [IW-1:0] id; logic [ADW-1:0] addr; logic [7:0] len;
    logic [2:0] size; logic [1:0] burst; logic [UW-1:0] user; logic [ADW-1:0] exp_last;
  } vec_t;

  logic clk, rst_n;
  logic [AX_W-1:0] ar_rdata, aw_rdata;
  logic [W_W-1:0]  w_rdata;
  logic ar_rempty, aw_rempty, w_rempty, ar_rden, aw_rden, w_rden;
  logic [B_W-1:0] b_wdata; logic b_wfull, b_wren;
  logic [R_W-1:0] r_wdata; logic r_wfull, r_wren;
  logic cmd_valid, cmd_ready, cmd_write;
  logic [ADW-1:0] cmd_addr; logic [DW-1:0] cmd_wdata; logic [SW-1:0] cmd_wstrb;
  logic rsp_valid, rsp_ready; logic [DW-1:0] rsp_data;

  ax_t ar_q[$], aw_q[$];
  w_t w_q[$];
  cmd_t exp_cmd[$];
  r_t exp_r[$];
  b_t exp_b[$];
  logic [DW-1:0] be_q[$];
  int grant_log[$];
  int checks, errors, cmd_cnt, r_cnt, b_cnt, rd_idx, be_idx;
  logic [ADW-1:0] last_cmd_addr;
  logic rdy_force, rsp_en, b_full, r_full;
  vec_t vecs[10];

  nasti_burst_sequencer #(
    .C_NASTI_ID_WIDTH(IW), .C_NASTI_ADDR_WIDTH(ADW), .C_NASTI_DATA_WIDTH(DW),
    .C_NASTI_USER_WIDTH(UW), .C_MAX_PENDING(MAXP)
  ) dut (
    .core_clk(clk), .core_arstn(rst_n),
    .ar_rdata(ar_rdata), .ar_rempty(ar_rempty), .ar_rden(ar_rden),
    .aw_rdata(aw_rdata), .aw_rempty(aw_rempty), .aw_rden(aw_rden),
    .w_rdata(w_rdata), .w_rempty(w_rempty), .w_rden(w_rden),
    .b_wdata(b_wdata), .b_wfull(b_wfull), .b_wren(b_wren),
    .r_wdata(r_wdata), .r_wfull(r_wfull), .r_wren(r_wren),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata), .cmd_wstrb(cmd_wstrb),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic fail(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    errors++;
    $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  function automatic logic [ADW-1:0] next_addr(input logic [ADW-1:0] a, input logic [7:0] len,
                                               input logic [2:0] size, input logic [1:0] burst);
    int step, bytes, ai, base;
    step = 1 << size;
    ai   = int'(a);
    if (burst == 2'd0) return a;
    if (burst == 2'd2 && (len == 1 || len == 3 || len == 7 || len == 15)) begin
      bytes = (int'(len) + 1) * step;
      base  = (ai / bytes) * bytes;
      return ADW'(base + ((ai - base + step) % bytes));
    end
    return ADW'(ai + step);
  endfunction

  task automatic submit(input logic wr, input logic [IW-1:0] id, input logic [ADW-1:0] addr,
                        input logic [7:0] len, input logic [2:0] size, input logic [1:0] burst,
                        input logic [UW-1:0] user, input logic bad_last);
    ax_t ax; w_t wb; cmd_t c; r_t r; b_t b; logic [ADW-1:0] a;
    ax = '{id: id, addr: addr, len: len, size: size, burst: burst, user: user};
    if (wr) aw_q.push_back(ax); else ar_q.push_back(ax);
    a = addr;
    for (int i = 0; i <= int'(len); i++) begin
      c = '0;
      c.write = wr;
      c.addr  = a;
      if (wr) begin
        wb.data = $urandom;
        wb.strb = SW'($urandom);
        wb.last = bad_last ? (i == 0) : (i == int'(len));
        wb.user = ~user;
        w_q.push_back(wb);
        c.wdata = wb.data;
        c.wstrb = wb.strb;
      end else begin
        r = '{id: id, data: RD_BASE + DW'(rd_idx), last: (i == int'(len)), resp: 2'b00, user: user};
        exp_r.push_back(r);
        rd_idx++;
      end
      exp_cmd.push_back(c);
      a = next_addr(a, len, size, burst);
    end
    if (wr) begin
      b = '{id: id, resp: (bad_last ? LAST_ERR_RESP : 2'b00), user: user};
      exp_b.push_back(b);
    end
  endtask

  task automatic clear_model();
    ar_q.delete(); aw_q.delete(); w_q.delete(); exp_cmd.delete(); exp_r.delete();
    exp_b.delete(); be_q.delete(); grant_log.delete();
    rd_idx = 0;
    be_idx = 0;
  endtask

  task automatic wait_done(input string name, input int maxc);
    int n = 0;
    while ((exp_cmd.size() + exp_r.size() + exp_b.size()) != 0 && n < maxc) begin
      tick(1);
      n++;
    end
    check(name, 64'(exp_cmd.size() + exp_r.size() + exp_b.size()), 64'd0);
  endtask

  task automatic check_zero(input string name);
    check({name, "_ctl"}, 64'({ar_rden, aw_rden, w_rden, b_wren, r_wren, cmd_valid, cmd_write, rsp_ready}), 64'd0);
    check({name, "_addr"}, 64'(cmd_addr), 64'd0);
    check({name, "_wdata"}, 64'({cmd_wdata, cmd_wstrb}), 64'd0);
    check({name, "_b"}, 64'(b_wdata), 64'd0);
    check({name, "_r"}, 64'(r_wdata), 64'd0);
  endtask

  // FIFO/backend models: drive at negedge, commit the handshakes the next posedge will see
  initial begin : model
    cmd_t e; r_t er; b_t eb;
    forever begin
      @(negedge clk);
      ar_rempty = (ar_q.size() == 0); ar_rdata = '0;
      if (!ar_rempty) ar_rdata = ar_q[0];
      aw_rempty = (aw_q.size() == 0); aw_rdata = '0;
      if (!aw_rempty) aw_rdata = aw_q[0];
      w_rempty = (w_q.size() == 0); w_rdata = '0;
      if (!w_rempty) w_rdata = w_q[0];
      cmd_ready = rdy_force ? 1'b1 : ($urandom_range(0, 3) != 0);
      rsp_valid = rsp_en && (be_q.size() != 0) && (rdy_force || $urandom_range(0, 3) != 0);
      rsp_data = '0;
      if (be_q.size() != 0) rsp_data = be_q[0];
      b_wfull = b_full;
      r_wfull = r_full;
      #1;
      if (rst_n) begin
        if (ar_rden) begin
          if (ar_q.size() == 0) fail("ar_pop_empty", 64'd1, 64'd0);
          else begin void'(ar_q.pop_front()); grant_log.push_back(0); end
        end
        if (aw_rden) begin
          if (aw_q.size() == 0) fail("aw_pop_empty", 64'd1, 64'd0);
          else begin void'(aw_q.pop_front()); grant_log.push_back(1); end
        end
        if (w_rden) begin
          if (w_q.size() == 0) fail("w_pop_empty", 64'd1, 64'd0);
          else void'(w_q.pop_front());
        end
        if (cmd_valid && cmd_ready) begin
          cmd_cnt++;
          last_cmd_addr = cmd_addr;
          if (exp_cmd.size() == 0) fail("cmd_unexpected", 64'(cmd_addr), 64'd0);
          else begin
            e = exp_cmd.pop_front();
            check("cmd_write", 64'(cmd_write), 64'(e.write));
            check("cmd_addr", 64'(cmd_addr), 64'(e.addr));
            if (e.write) check("cmd_wdata_strb", 64'({cmd_wdata, cmd_wstrb}), 64'({e.wdata, e.wstrb}));
          end
          if (!cmd_write) begin
            be_q.push_back(RD_BASE + DW'(be_idx));
            be_idx++;
          end
        end
        if (rsp_valid && rsp_ready) void'(be_q.pop_front());
        if (r_wren) begin
          r_cnt++;
          check("r_push_while_full", 64'(r_wfull), 64'd0);
          if (exp_r.size() == 0) fail("r_unexpected", 64'(r_wdata), 64'd0);
          else begin er = exp_r.pop_front(); check("r_wdata", 64'(r_wdata), 64'(er)); end
        end
        if (b_wren) begin
          b_cnt++;
          check("b_push_while_full", 64'(b_wfull), 64'd0);
          if (exp_b.size() == 0) fail("b_unexpected", 64'(b_wdata), 64'd0);
          else begin eb = exp_b.pop_front(); check("b_wdata", 64'(b_wdata), 64'(eb)); end
        end
      end
    end
  end

  initial begin : main
    int c0, n;
    logic [3:0] gv;
    checks = 0; errors = 0; cmd_cnt = 0; r_cnt = 0; b_cnt = 0; rd_idx = 0; be_idx = 0;
    last_cmd_addr = '0;
    rdy_force = 1'b0; rsp_en = 1'b1; b_full = 1'b0; r_full = 1'b0;
    ar_rdata = '0; aw_rdata = '0; w_rdata = '0; ar_rempty = 1'b1; aw_rempty = 1'b1; w_rempty = 1'b1;
    b_wfull = 1'b0; r_wfull = 1'b0; cmd_ready = 1'b0; rsp_valid = 1'b0; rsp_data = '0;

    //           wr    id    addr      len    size  burst user  last addr
    vecs[0] = '{1'b0, 4'h1, 16'h0100, 8'd3,  3'd3, 2'd1, 2'd1, 16'h0118};
    vecs[1] = '{1'b1, 4'h2, 16'h001C, 8'd3,  3'd2, 2'd2, 2'd2, 16'h0018};
    vecs[2] = '{1'b0, 4'h3, 16'h0040, 8'd2,  3'd2, 2'd0, 2'd3, 16'h0040};
    vecs[3] = '{1'b0, 4'h4, 16'hFFF8, 8'd2,  3'd3, 2'd1, 2'd0, 16'h0008};
    vecs[4] = '{1'b1, 4'h5, 16'h0020, 8'd2,  3'd2, 2'd2, 2'd1, 16'h0028};
    vecs[5] = '{1'b1, 4'h6, 16'h0030, 8'd1,  3'd1, 2'd3, 2'd2, 16'h0032};
    vecs[6] = '{1'b0, 4'h7, 16'h0007, 8'd7,  3'd0, 2'd2, 2'd3, 16'h0006};
    vecs[7] = '{1'b1, 4'h8, 16'h0200, 8'd0,  3'd2, 2'd1, 2'd0, 16'h0200};
    vecs[8] = '{1'b0, 4'h9, 16'h03F0, 8'd15, 3'd2, 2'd2, 2'd1, 16'h03EC};
    vecs[9] = '{1'b0, 4'hA, 16'h0050, 8'd0,  3'd3, 2'd1, 2'd2, 16'h0050};

    rst_n = 1'b0;
    tick(3);
    check_zero("reset");
    rst_n = 1'b1;
    tick(1);

    for (int i = 0; i < 10; i++) begin
      submit(vecs[i].wr, vecs[i].id, vecs[i].addr, vecs[i].len, vecs[i].size, vecs[i].burst, vecs[i].user, 1'b0);
      wait_done($sformatf("vec%0d_done", i), 600);
      check($sformatf("vec%0d_last_addr", i), 64'(last_cmd_addr), 64'(vecs[i].exp_last));
    end

    // both directions pending straight out of reset
    rst_n = 1'b0;
    clear_model();
    submit(1'b0, 4'h1, 16'h1000, 8'd1, 3'd2, 2'd1, 2'd0, 1'b0);
    submit(1'b1, 4'h2, 16'h2000, 8'd1, 3'd2, 2'd1, 2'd1, 1'b0);
    submit(1'b0, 4'h3, 16'h3000, 8'd1, 3'd2, 2'd1, 2'd2, 1'b0);
    submit(1'b1, 4'h4, 16'h4000, 8'd1, 3'd2, 2'd1, 2'd3, 1'b0);
    tick(2);
    rst_n = 1'b1;
    wait_done("arb_done", 400);
    gv = '0;
    for (int i = 0; i < grant_log.size() && i < 4; i++) gv[i] = grant_log[i][0];
    check("grant_order", 64'({grant_log.size(), gv}), 64'({32'd4, 4'b1010}));

    // tag queue fills with rsp_valid held low
    rdy_force = 1'b1; rsp_en = 1'b0;
    c0 = cmd_cnt;
    submit(1'b0, 4'h5, 16'h0500, 8'd7, 3'd2, 2'd1, 2'd1, 1'b0);
    tick(20);
    check("pend_cmd_count", 64'(cmd_cnt - c0), 64'd5);
    check("pend_cmd_valid", 64'(cmd_valid), 64'd0);
    r_full = 1'b1; rsp_en = 1'b1;
    c0 = r_cnt;
    tick(10);
    check("rfull_no_push", 64'(r_cnt - c0), 64'd0);
    check("rfull_rsp_ready", 64'(rsp_ready), 64'd0);
    r_full = 1'b0;
    wait_done("rfull_drain", 300);
    check("rfull_r_count", 64'(r_cnt - c0), 64'd8);

    b_full = 1'b1;
    c0 = b_cnt;
    submit(1'b1, 4'h6, 16'h0600, 8'd1, 3'd2, 2'd1, 2'd2, 1'b0);
    tick(15);
    check("bfull_no_push", 64'(b_cnt - c0), 64'd0);
    check("bfull_b_wren", 64'(b_wren), 64'd0);
    b_full = 1'b0;
    wait_done("bfull_drain", 100);
    check("bfull_b_count", 64'(b_cnt - c0), 64'd1);

    // w_last asserted on the wrong beat
    rdy_force = 1'b0;
    submit(1'b1, 4'hB, 16'h0060, 8'd1, 3'd2, 2'd1, 2'd1, 1'b1);
    wait_done("last_chk_done", 200);
    submit(1'b1, 4'hE, 16'h0070, 8'd1, 3'd2, 2'd1, 2'd2, 1'b0);
    wait_done("last_ok_after_err", 200);

    // reset in the middle of a 16-beat write
    rdy_force = 1'b1;
    c0 = cmd_cnt;
    submit(1'b1, 4'hC, 16'h0400, 8'd15, 3'd2, 2'd1, 2'd0, 1'b0);
    n = 0;
    while ((cmd_cnt - c0) < 5 && n < 100) begin tick(1); n++; end
    check("rst_mid_progress", 64'((cmd_cnt - c0) >= 5), 64'd1);
    rst_n = 1'b0;
    clear_model();
    #1;
    check_zero("rst_mid");
    tick(2);
    rst_n = 1'b1;
    submit(1'b0, 4'hD, 16'h0080, 8'd1, 3'd3, 2'd1, 2'd3, 1'b0);
    wait_done("post_rst_done", 200);
    check("post_rst_last_addr", 64'(last_cmd_addr), 64'h0088);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
